enemy_path_sched: RTL

Time-shares the single-port enemy path ROM among NUM_ENEMIES enemy units.
- Once per movement tick it sweeps all enemies in index order.
- For each live enemy it issues one ROM read at that enemy's phase-shifted address inside the current level's pattern window.
- It delivers each returned word to that enemy with a one-cycle valid strobe.
- It sits between the level/game controller and the per-enemy position/draw logic.

---
 rtl/enemy_path_sched.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/enemy_path_sched.sv
// enemy_path_sched: time-shares the enemy path ROM, one phase-shifted
// read per live enemy per movement tick, words delivered with a strobe.
// Ports: pclk, rst_n (async, active low); level/level_load from the
// level controller; enemy_alive mask; rom_addr/rom_data to the sync ROM;
// pos_data/pos_valid per enemy; frame_done at sweep end; busy != IDLE.
module enemy_path_sched #(
  parameter int NUM_ENEMIES = 4,
  parameter int TICK_LIMIT  = 1000000,
  parameter int LEVEL_LEN   = 150,
  parameter int PHASE_STEP  = 37,
  parameter int DATA_W      = 12
) (
  input  logic                          pclk,
  input  logic                          rst_n,
  input  logic [3:0]                    level,
  input  logic                          level_load,
  input  logic [NUM_ENEMIES-1:0]        enemy_alive,
  output logic [11:0]                   rom_addr,
  input  logic [DATA_W-1:0]             rom_data,
  output logic [NUM_ENEMIES*DATA_W-1:0] pos_data,
  output logic [NUM_ENEMIES-1:0]        pos_valid,
  output logic                          frame_done,
  output logic                          busy
);

  localparam int TW = (TICK_LIMIT > 1) ? $clog2(TICK_LIMIT) : 1;
  localparam int IW = (NUM_ENEMIES > 1) ? $clog2(NUM_ENEMIES) : 1;
  // wide enough for off + PHASE_STEP before the wrap subtract
  localparam int OW = $clog2(LEVEL_LEN + PHASE_STEP + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_CAPTURE,
    S_ADVANCE
  } state_t;

  state_t r_state;
  state_t w_state_n;

  logic [3:0]                    r_level_q;
  logic [OW-1:0]                 r_step;
  logic [OW-1:0]                 r_off;
  logic [IW-1:0]                 r_idx;
  logic [TW-1:0]                 r_tick_cnt;
  logic [11:0]                   r_rom_addr;
  logic [NUM_ENEMIES*DATA_W-1:0] r_pos_data;
  logic [NUM_ENEMIES-1:0]        r_pos_valid;
  logic                          r_frame_done;

  logic          w_tick;
  logic          w_last;
  logic [3:0]    w_lvl_m1;
  logic [11:0]   w_base;
  logic [11:0]   w_addr;
  logic [OW-1:0] w_off_sum;
  logic [OW-1:0] w_off_nxt;
  logic          w_start;
  logic          w_issue;
  logic          w_step_off;
  logic          w_idx_inc;
  logic          w_capture;
  logic          w_advance;

  assign w_tick    = (r_tick_cnt == TW'(TICK_LIMIT - 1));
  assign w_last    = (r_idx == IW'(NUM_ENEMIES - 1));
  assign w_lvl_m1  = r_level_q - 4'd1;
  assign w_base    = 12'(LEVEL_LEN) * {8'd0, w_lvl_m1};
  assign w_addr    = w_base + 12'(r_off);
  assign w_off_sum = r_off + OW'(PHASE_STEP);
  assign w_off_nxt = (w_off_sum >= OW'(LEVEL_LEN)) ?
                     (w_off_sum - OW'(LEVEL_LEN)) : w_off_sum;

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_n;
  end

  always_comb begin
    w_state_n  = r_state;
    w_start    = 1'b0;
    w_issue    = 1'b0;
    w_step_off = 1'b0;
    w_idx_inc  = 1'b0;
    w_capture  = 1'b0;
    w_advance  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_tick) begin
          w_start   = 1'b1;
          w_state_n = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (enemy_alive[r_idx]) begin
          w_issue   = 1'b1;
          w_state_n = S_WAIT;
        end else begin
          w_step_off = 1'b1;
          if (w_last) w_state_n = S_ADVANCE;
          else        w_idx_inc = 1'b1;
        end
      end
      S_WAIT: w_state_n = S_CAPTURE;
      S_CAPTURE: begin
        w_capture  = 1'b1;
        w_step_off = 1'b1;
        if (w_last) begin
          w_state_n = S_ADVANCE;
        end else begin
          w_idx_inc = 1'b1;
          w_state_n = S_ISSUE;
        end
      end
      S_ADVANCE: begin
        w_advance = 1'b1;
        w_state_n = S_IDLE;
      end
      default: w_state_n = S_IDLE;
    endcase
    // a level change abandons the sweep, including any in-flight read
    if (level_load) begin
      w_state_n  = S_IDLE;
      w_start    = 1'b0;
      w_issue    = 1'b0;
      w_step_off = 1'b0;
      w_idx_inc  = 1'b0;
      w_capture  = 1'b0;
      w_advance  = 1'b0;
    end
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_level_q    <= 4'd1;
      r_step       <= '0;
      r_off        <= '0;
      r_idx        <= '0;
      r_tick_cnt   <= '0;
      r_rom_addr   <= '0;
      r_pos_data   <= '0;
      r_pos_valid  <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_pos_valid  <= '0;
      r_frame_done <= 1'b0;
      r_tick_cnt   <= w_tick ? '0 : r_tick_cnt + 1'b1;
      if (level_load) begin
        r_level_q  <= (level == 4'd0) ? 4'd1 : level;
        r_step     <= '0;
        r_tick_cnt <= '0;
      end
      if (w_start) begin
        r_idx <= '0;
        r_off <= r_step;
      end
      if (w_issue)    r_rom_addr <= w_addr;
      if (w_step_off) r_off      <= w_off_nxt;
      if (w_idx_inc)  r_idx      <= r_idx + 1'b1;
      if (w_capture) begin
        r_pos_data[r_idx*DATA_W +: DATA_W] <= rom_data;
        r_pos_valid <= NUM_ENEMIES'(1) << r_idx;
      end
      if (w_advance) begin
        r_step <= (r_step == OW'(LEVEL_LEN - 1)) ?
                  '0 : r_step + 1'b1;
        r_frame_done <= 1'b1;
      end
    end
  end

  assign rom_addr   = r_rom_addr;
  assign pos_data   = r_pos_data;
  assign pos_valid  = r_pos_valid;
  assign frame_done = r_frame_done;
  assign busy       = (r_state != S_IDLE);

endmodule
